// File: rtl/button_events_pkg.sv
// Shared constants and FSM encoding for the button event decoder.
package button_events_pkg;

  localparam int unsigned CNT_W = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

endpackage

// File: rtl/button_events_one.sv
// Single-channel press/release/long-press/auto-repeat event generator.
// Auto-repeat counting is enabled by defining BUTTON_EVENTS_AUTOREPEAT_EN.
module button_events_one
  import button_events_pkg::*;
#(
  parameter int unsigned long_cycles   = 1000,
  parameter int unsigned repeat_cycles = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic press,
  output logic release_ev,
  output logic long_press,
  output logic repeat_ev,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(long_cycles);

  state_t           state;
  logic             prev;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             fall;

  assign rise = sw_in & ~prev;
  assign fall = ~sw_in & prev;
  assign held = prev;

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_TH = CNT_W'(repeat_cycles);
`else
  logic [CNT_W-1:0] unused_repeat_th;
  assign unused_repeat_th = CNT_W'(repeat_cycles);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= 1'b0;
      cnt        <= '0;
      press      <= 1'b0;
      release_ev <= 1'b0;
      long_press <= 1'b0;
      repeat_ev  <= 1'b0;
    end else begin
      prev       <= sw_in;
      press      <= rise;
      release_ev <= fall;
      long_press <= 1'b0;
      repeat_ev  <= 1'b0;
      // A falling edge takes priority over any threshold hit in the same cycle.
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESSED;
            cnt   <= CNT_W'(1);
          end
        end
        PRESSED: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == LONG_TH) begin
            long_press <= 1'b1;
            state      <= LONG;
            cnt        <= CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LONG: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
            if (cnt == REP_TH) begin
              repeat_ev <= 1'b1;
              cnt       <= CNT_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
`endif
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_events.sv
// Multi-channel button event decoder: one independent button_events_one per channel.
// Auto-repeat is enabled by defining BUTTON_EVENTS_AUTOREPEAT_EN.
module button_events
  import button_events_pkg::*;
#(
  parameter int unsigned w             = 1,
  parameter int unsigned long_cycles   = 1000,
  parameter int unsigned repeat_cycles = 250
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [w-1:0] sw_in,
  output logic [w-1:0] press,
  output logic [w-1:0] release_ev,
  output logic [w-1:0] long_press,
  output logic [w-1:0] repeat_ev,
  output logic [w-1:0] held
);

  for (genvar i = 0; i < w; i++) begin : g_ch
    button_events_one #(
      .long_cycles  (long_cycles),
      .repeat_cycles(repeat_cycles)
    ) u_one (
      .clk       (clk),
      .reset     (reset),
      .sw_in     (sw_in[i]),
      .press     (press[i]),
      .release_ev(release_ev[i]),
      .long_press(long_press[i]),
      .repeat_ev (repeat_ev[i]),
      .held      (held[i])
    );
  end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events (w=2, long=8, repeat=4) with an event scoreboard.
module tb_button_events;

  localparam int unsigned W   = 2;
  localparam int          LC  = 8;
  localparam int          RC  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_in;
  logic [W-1:0] press, release_ev, long_press, repeat_ev, held;

  typedef struct {
    int cyc;
    int ch;
    int kind;  // 0 press, 1 release, 2 long_press, 3 repeat
  } ev_t;

  ev_t          sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  bit           checking = 1'b0;
  logic [W-1:0] exp_held;

  button_events #(
    .w            (W),
    .long_cycles  (LC),
    .repeat_cycles(RC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_in     (sw_in),
    .press     (press),
    .release_ev(release_ev),
    .long_press(long_press),
    .repeat_ev (repeat_ev),
    .held      (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) exp_held <= reset ? '0 : sw_in;

  function automatic void push(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endfunction

  // Expected pulses for a channel held high during cycles t0 .. t0+len-1.
  function automatic void push_hold(input int t0, input int ch, input int len);
    push(t0 + 1, ch, 0);
    push(t0 + len + 1, ch, 1);
    if (len >= LC + 1) begin
      push(t0 + 1 + LC, ch, 2);
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
      for (int j = 1; 1 + LC + RC * j <= len; j++)
        push(t0 + 1 + LC + RC * j, ch, 3);
`endif
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_window(input int s0, input int l0, input int s1, input int l1, input int n);
    if (l0 > 0) push_hold(cyc + s0, 0, l0);
    if (l1 > 0) push_hold(cyc + s1, 1, l1);
    for (int k = 0; k < n; k++) begin
      sw_in[0] = (l0 > 0) && (k >= s0) && (k < s0 + l0);
      sw_in[1] = (l1 > 0) && (k >= s1) && (k < s1 + l1);
      step();
    end
    sw_in = '0;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      logic [W-1:0] ep, er, el, et;
      ep = '0; er = '0; el = '0; et = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            0: ep[sb[i].ch] = 1'b1;
            1: er[sb[i].ch] = 1'b1;
            2: el[sb[i].ch] = 1'b1;
            default: et[sb[i].ch] = 1'b1;
          endcase
          sb.delete(i);
        end
      end
      checks++;
      assert (press === ep) else begin
        errors++;
        $error("FAIL press cyc=%0d observed=%b expected=%b", cyc, press, ep);
      end
      checks++;
      assert (release_ev === er) else begin
        errors++;
        $error("FAIL release cyc=%0d observed=%b expected=%b", cyc, release_ev, er);
      end
      checks++;
      assert (long_press === el) else begin
        errors++;
        $error("FAIL long_press cyc=%0d observed=%b expected=%b", cyc, long_press, el);
      end
      checks++;
      assert (repeat_ev === et) else begin
        errors++;
        $error("FAIL repeat cyc=%0d observed=%b expected=%b", cyc, repeat_ev, et);
      end
      checks++;
      assert (held === exp_held) else begin
        errors++;
        $error("FAIL held cyc=%0d observed=%b expected=%b", cyc, held, exp_held);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete at cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    reset = 1'b1;
    sw_in = '0;
    step();
    checking = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    step();

    // Short tap on channel 0
    run_window(1, 3, 0, 0, 8);
    // Long hold through long-press and repeats
    run_window(0, 20, 0, 0, 25);
    // Release coinciding with the long-press threshold
    run_window(0, LC, 0, 0, 12);
    // Both channels held, offset by three cycles
    run_window(0, 20, 3, 20, 28);

    // Reset in the middle of a hold, button still down afterwards
    t = cyc;
    sw_in[0] = 1'b1;
    push(t + 1, 0, 0);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    push(t + 6, 0, 0);
    repeat (4) step();
    sw_in[0] = 1'b0;
    push(cyc + 1, 0, 1);
    repeat (4) step();

    // Reset while idle leaves everything quiet
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();

    checking = 1'b0;
    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
